// File: rtl/inst_rom_arbiter_pkg.sv
// inst_rom_arbiter_pkg: shared CPU defines for ROM addressing and arbitration.
package inst_rom_arbiter_pkg;
  localparam int ROM_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  typedef logic [WAIT_W-1:0] wait_t;
  function automatic logic misaligned(input logic [1:0] lsb);
    return |(lsb & ALIGN_MASK);
  endfunction
endpackage

// File: rtl/inst_rom_arbiter_prio_sel.sv
// rom_prio_sel: fetch-first priority with a starvation override for debug.
module rom_prio_sel
  import inst_rom_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              if_req,
  input  logic              dbg_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  output logic              if_gnt,
  output logic              dbg_gnt
);
  always_comb begin
    dbg_gnt = dbg_req && (!if_req || wait_cnt == WAIT_W'(MAX_WAIT));
    if_gnt = if_req && !dbg_gnt;
  end
endmodule

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares one combinational instruction ROM between fetch and debug ports.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [INST_W-1:0] if_data,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [INST_W-1:0] dbg_data,
  output logic              dbg_err,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst
);
  wait_t             wait_cnt;
  logic              if_pend_v;
  logic [INST_W-1:0] if_pend;
  logic [INST_W-1:0] if_hold;
  logic              dbg_mis;
  logic              dbg_rom;
  rom_prio_sel #(.MAX_WAIT(MAX_WAIT)) u_sel (
    .if_req  (if_req & rst),
    .dbg_req (dbg_req & rst),
    .wait_cnt(wait_cnt),
    .if_gnt  (if_gnt),
    .dbg_gnt (dbg_gnt)
  );
  // A misaligned debug access is answered with an error and never touches the ROM.
  always_comb begin
    dbg_mis = misaligned(dbg_addr[1:0]);
    dbg_rom = dbg_gnt && !dbg_mis;
    rom_ce = if_gnt || dbg_rom;
    rom_addr = if_gnt ? if_addr : dbg_rom ? dbg_addr : '0;
    if_valid = if_pend_v && !if_flush;
    if_data = if_valid ? if_pend : if_hold;
  end
  // if_pend carries the word in flight so a late flush leaves if_data at its old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      if_pend_v <= 1'b0;
      if_pend <= '0;
      if_hold <= '0;
      dbg_valid <= 1'b0;
      dbg_err <= 1'b0;
      dbg_data <= '0;
    end else begin
      wait_cnt <= dbg_gnt ? '0 : (dbg_req && wait_cnt != WAIT_W'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
      if_pend_v <= if_gnt && !if_flush;
      if (if_gnt) if_pend <= rom_inst;
      if (if_valid) if_hold <= if_pend;
      dbg_valid <= dbg_gnt;
      dbg_err <= dbg_gnt && dbg_mis;
      if (dbg_gnt) dbg_data <= dbg_mis ? '0 : rom_inst;
    end
  end
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb_inst_rom_arbiter: directed steps with a response scoreboard and immediate assertions.
module tb_inst_rom_arbiter;
  typedef struct {
    logic        dbg;
    logic [31:0] data;
    logic        err;
  } resp_t;
  logic        clk, rst;
  logic        if_req, if_flush, if_gnt, if_valid;
  logic [31:0] if_addr, if_data;
  logic        dbg_req, dbg_gnt, dbg_valid, dbg_err;
  logic [31:0] dbg_addr, dbg_data;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_inst;
  int          checks = 0;
  int          errors = 0;
  resp_t       sb[$];
  logic [31:0] m_if_data = 0;
  logic [31:0] m_dbg_data = 0;
  inst_rom_arbiter #(.MAX_WAIT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_data(if_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h34011100 : {a[15:0] ^ 16'h5a00, ~a[15:0]};
  endfunction
  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'hdeadbeef;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                     input logic fl, input logic eig, input logic edg, input string tag);
    resp_t e;
    logic exp_iv, exp_dv, exp_de, mis;
    if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da; if_flush = fl;
    #1;
    exp_iv = 0; exp_dv = 0; exp_de = 0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dbg) begin
        exp_dv = 1; exp_de = e.err; m_dbg_data = e.data;
      end else if (!fl) begin
        exp_iv = 1; m_if_data = e.data;
      end
    end
    chk(32'(if_valid), 32'(exp_iv), {tag, " if_valid"});
    chk(if_data, m_if_data, {tag, " if_data"});
    chk(32'(dbg_valid), 32'(exp_dv), {tag, " dbg_valid"});
    chk(32'(dbg_err), 32'(exp_de), {tag, " dbg_err"});
    chk(dbg_data, m_dbg_data, {tag, " dbg_data"});
    chk(32'(if_gnt), 32'(eig), {tag, " if_gnt"});
    chk(32'(dbg_gnt), 32'(edg), {tag, " dbg_gnt"});
    mis = da[1:0] != 2'b00;
    chk(32'(rom_ce), 32'(eig || (edg && !mis)), {tag, " rom_ce"});
    chk(rom_addr, eig ? ia : (edg && !mis) ? da : 32'h0, {tag, " rom_addr"});
    if (eig && !fl) sb.push_back('{dbg: 1'b0, data: rom_word(ia), err: 1'b0});
    if (edg) sb.push_back('{dbg: 1'b1, data: mis ? 32'h0 : rom_word(da), err: mis});
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk(32'(if_gnt), 0, {tag, " if_gnt"});
    chk(32'(dbg_gnt), 0, {tag, " dbg_gnt"});
    chk(32'(rom_ce), 0, {tag, " rom_ce"});
    chk(rom_addr, 0, {tag, " rom_addr"});
    chk(32'(if_valid), 0, {tag, " if_valid"});
    chk(32'(dbg_valid), 0, {tag, " dbg_valid"});
    chk(32'(dbg_err), 0, {tag, " dbg_err"});
    chk(if_data, 0, {tag, " if_data"});
    chk(dbg_data, 0, {tag, " dbg_data"});
    chk(32'(dut.wait_cnt), 0, {tag, " wait_cnt"});
  endtask
  initial begin
    rst = 0; if_req = 1; if_addr = 32'h10; dbg_req = 1; dbg_addr = 32'h40; if_flush = 0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    // single fetch
    cyc(1, 32'h10, 0, 0, 0, 1, 0, "fetch10");
    cyc(0, 0, 0, 0, 0, 0, 0, "fetch10_resp");
    // starvation: fetch wins four times, then debug, then fetch again
    for (int i = 0; i < 4; i++) cyc(1, 32'h4, 1, 32'h40, 0, 1, 0, $sformatf("starve%0d", i));
    chk(32'(dut.wait_cnt), 4, "starve wait_cnt");
    cyc(1, 32'h4, 1, 32'h40, 0, 0, 1, "starve4");
    cyc(1, 32'h4, 1, 32'h40, 0, 1, 0, "starve5");
    // dropped debug request gets no response
    cyc(0, 0, 0, 0, 0, 0, 0, "drop");
    // misaligned debug access
    cyc(0, 0, 1, 32'h6, 0, 0, 1, "mis6");
    cyc(0, 0, 0, 0, 0, 0, 0, "mis6_resp");
    // flush in the response cycle, then in the grant cycle
    cyc(1, 32'h20, 0, 0, 0, 1, 0, "flush20");
    cyc(0, 0, 0, 0, 1, 0, 0, "flush20_resp");
    cyc(1, 32'h24, 0, 0, 1, 1, 0, "flush24");
    cyc(0, 0, 0, 0, 0, 0, 0, "flush24_resp");
    // back-to-back fetches
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0, 0, 1, 0, $sformatf("b2b%0d", i));
    cyc(0, 0, 0, 0, 0, 0, 0, "b2b_resp");
    // aligned debug read on an idle ROM
    cyc(0, 0, 1, 32'h48, 0, 0, 1, "dbg48");
    cyc(0, 0, 0, 0, 0, 0, 0, "dbg48_resp");
    // reset with a fetch response in flight and a nonzero wait count
    cyc(1, 32'h30, 1, 32'h44, 0, 1, 0, "pre_reset");
    rst = 0;
    sb.delete();
    m_if_data = 0;
    m_dbg_data = 0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_reset2");
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0, 0, "post_reset");
    cyc(1, 32'h10, 0, 0, 0, 1, 0, "post_fetch");
    cyc(0, 0, 0, 0, 0, 0, 0, "post_fetch_resp");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
